// File: rtl/memory_word_access_unit.sv
// memory_word_access_unit
//   Performs a 16-bit word load or store against byte-wide memory. The word
//   address comes from the address register file (OutD). Each word is moved
//   as two byte transactions over a req/ack handshake: the low byte at addr,
//   then the high byte at addr+1 (wrapping at 0xFFFF). A one-cycle GAP with
//   mem_req low separates the two bytes. A per-byte timeout ends the transfer
//   with err set when memory never acknowledges.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               single-cycle request; write/addr/wdata sampled with it
//   write               1 = store, 0 = load
//   addr[15:0]          word base address
//   wdata[15:0]         store data
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   err                 timeout flag, valid with done, held until next start
//   rdata[15:0]         last successfully loaded word
//   mem_req, mem_we     byte request strobe / byte write enable
//   mem_addr[15:0]      byte address
//   mem_wdata[7:0]      byte store data
//   mem_rdata[7:0]      byte load data, valid with mem_ack
//   mem_ack             memory accepts / completes the current byte
module memory_word_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_GAP,
    S_HI,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN  = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;

  // Command / staging registers: only meaningful while a transfer is active,
  // so they carry no reset.
  logic [15:0]      addr_q;
  logic [7:0]       wdata_hi_q;
  logic             write_q;
  logic [7:0]       lo_q;
  logic             cap_cmd, cap_lo;

  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  // Next-state and register-update logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cap_cmd     = 1'b0;
    cap_lo      = 1'b0;

    // Counter value after this cycle's wait; hitting the limit ends the byte.
    cnt_inc = cnt_q + 1'b1;
    timeout = TO_EN && (cnt_inc == TO_LIM);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LO;
          err_d       = 1'b0;
          cnt_d       = '0;
          cap_cmd     = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = wdata[7:0];
        end
      end
      S_LO: begin
        if (mem_ack) begin
          state_d     = S_GAP;
          cap_lo      = ~write_q;
          // Pre-load the high-byte address/data so they are already stable
          // when the request reasserts in HI.
          mem_addr_d  = addr_q + 16'd1;
          mem_wdata_d = wdata_hi_q;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        state_d = S_HI;
        cnt_d   = '0;
      end
      S_HI: begin
        if (mem_ack) begin
          state_d = S_DONE;
          if (!write_q) begin
            rdata_d = {mem_rdata, lo_q};
          end
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Command capture and low-byte staging
  always_ff @(posedge clock) begin
    if (cap_cmd) begin
      addr_q     <= addr;
      wdata_hi_q <= wdata[15:8];
      write_q    <= write;
    end
    if (cap_lo) begin
      lo_q <= mem_rdata;
    end
  end

  // Moore outputs: strobes decode only the state register, so reset drops
  // mem_req at once and mem_ack has no combinational path to mem_req.
  assign mem_req   = (state_q == S_LO) || (state_q == S_HI);
  assign mem_we    = mem_req & write_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_word_access_unit.sv
module tb_memory_word_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack   = 1'b0;

  memory_word_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .write     (write),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          st;
    int          lat;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [7:0]  wd;
  } bt_t;

  sb_t        sb_q[$];
  bt_t        bt_q[$];
  sb_t        mon_e;
  bt_t        rsp_e;
  logic [7:0] mem [0:65535];

  int   cyc       = 0;
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   n_done    = 0;
  int   waits     = 0;
  int   acks_left = 0;
  int   wcnt      = 0;
  logic prev_ack  = 1'b0;
  logic [15:0] hold_a  = 16'h0;
  logic [7:0]  hold_wd = 8'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Memory responder + completion monitor, all sampled at the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      mem_ack  = 1'b0;
      wcnt     = 0;
      prev_ack = 1'b0;
    end else begin
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mon_e = sb_q.pop_front();
          chk("rdata", rdata, mon_e.rdata);
          chk("err", err, mon_e.err);
          chk("latency", cyc - mon_e.st + 1, mon_e.lat);
        end
      end

      if (prev_ack) chk("req_gap", mem_req, 1'b0);
      prev_ack = 1'b0;
      mem_ack  = 1'b0;

      if (mem_req) begin
        if (wcnt == 0) begin
          hold_a  = mem_addr;
          hold_wd = mem_wdata;
        end
        if (acks_left > 0 && wcnt >= waits) begin
          if (wcnt > 0) begin
            chk("req_stable_addr", mem_addr, hold_a);
            if (mem_we) chk("req_stable_wdata", mem_wdata, hold_wd);
          end
          if (bt_q.size() == 0) begin
            fail_now("unexpected_byte");
          end else begin
            rsp_e = bt_q.pop_front();
            chk("byte_addr", mem_addr, rsp_e.a);
            chk("byte_we", mem_we, rsp_e.we);
            if (rsp_e.we) chk("byte_wdata", mem_wdata, rsp_e.wd);
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          mem_rdata = mem[mem_addr];
          mem_ack   = 1'b1;
          prev_ack  = 1'b1;
          acks_left--;
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Queue expectations for one transfer and drive start for 'hold' cycles.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input int w, input int nack, input logic [15:0] erd,
                       input logic eerr, input int elat, input int hold);
    bt_t b;
    sb_t s;
    waits     = w;
    acks_left = nack;
    b.a  = a;
    b.we = we;
    b.wd = wd[7:0];
    bt_q.push_back(b);
    if (nack >= 2) begin
      b.a  = a + 16'd1;
      b.wd = wd[15:8];
      bt_q.push_back(b);
    end
    s.rdata = erd;
    s.err   = eerr;
    s.st    = cyc + 1;
    s.lat   = elat;
    sb_q.push_back(s);
    write = we;
    addr  = a;
    wdata = wd;
    start = 1'b1;
    repeat (hold) @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 300; i++) begin
      if (done) break;
      @(negedge clock);
    end
    if (i >= 300) fail_now(nm);
    @(negedge clock);
  endtask

  initial begin
    int k;
    for (int j = 0; j < 65536; j++) mem[j] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    write = 1'b0;
    addr  = 16'h0;
    wdata = 16'h0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    reset = 1'b0;
    @(negedge clock);

    // Zero-wait load
    mem[16'h0040] = 8'h34;
    mem[16'h0041] = 8'h12;
    issue(1'b0, 16'h0040, 16'h0000, 0, 2, 16'h1234, 1'b0, 4, 1);
    wait_done("done_timeout_load");

    // Store, two wait states per byte
    issue(1'b1, 16'h0100, 16'hBEEF, 2, 2, 16'h1234, 1'b0, 8, 1);
    wait_done("done_timeout_store");
    chk("store_lo_mem", mem[16'h0100], 8'hEF);
    chk("store_hi_mem", mem[16'h0101], 8'hBE);

    // Address wrap
    mem[16'hFFFF] = 8'hAA;
    mem[16'h0000] = 8'h55;
    issue(1'b0, 16'hFFFF, 16'h0000, 0, 2, 16'h55AA, 1'b0, 4, 1);
    wait_done("done_timeout_wrap");

    // High byte never acknowledged: 1 LO + 1 GAP + 16 HI + DONE
    issue(1'b0, 16'h0200, 16'h0000, 0, 1, 16'h55AA, 1'b1, 19, 1);
    wait_done("done_timeout_to");
    repeat (2) @(negedge clock);
    chk("err_hold", err, 1'b1);
    chk("rdata_hold", rdata, 16'h55AA);
    issue(1'b0, 16'h0040, 16'h0000, 0, 2, 16'h1234, 1'b0, 4, 1);
    chk("err_clear", err, 1'b0);
    wait_done("done_timeout_after_to");

    // Asynchronous reset during HI
    issue(1'b0, 16'h0040, 16'h0000, 3, 2, 16'h1234, 1'b0, 10, 1);
    for (k = 0; k < 50; k++) begin
      if (mem_req && mem_addr == 16'h0041) break;
      @(negedge clock);
    end
    if (k >= 50) fail_now("hi_not_reached");
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rdata", rdata, 16'h0000);
    chk("arst_mem_addr", mem_addr, 16'h0000);
    sb_q.delete();
    bt_q.delete();
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    issue(1'b0, 16'hFFFF, 16'h0000, 0, 2, 16'h55AA, 1'b0, 4, 1);
    wait_done("done_timeout_post_reset");

    // start held six cycles -> one transfer; start during DONE ignored
    issue(1'b0, 16'h0040, 16'h0000, 2, 2, 16'h1234, 1'b0, 8, 6);
    for (k = 0; k < 50; k++) begin
      if (done) break;
      @(negedge clock);
    end
    if (k >= 50) fail_now("done_timeout_held");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_done_start", busy, 1'b0);
    repeat (4) @(negedge clock);
    chk("busy_idle", busy, 1'b0);
    chk("done_count", n_done, 7);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_word_access_unit.md
Name: memory_word_access_unit

Overview:
- Sits directly downstream of the address register file. Takes the 16-bit address it presents on OutD and performs a 16-bit word read or write against byte-wide memory.
- Each word transfer is split into two byte transactions over a req/ack handshake, with the low byte at addr and the high byte at addr+1.
- Assembled read words go to the instruction/data register load path. A per-transaction timeout flags memory that never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 16: cycles a byte request may wait for mem_ack before aborting; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a word transfer
- write  input  1  1 = store, 0 = load; sampled with start
- addr  input  16  word base address (OutD of address register file); sampled with start
- wdata  input  16  store data; sampled with start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  timeout flag, valid with done
- rdata  output  16  last successfully loaded word
- mem_req  output  1  byte request strobe
- mem_we  output  1  byte write enable
- mem_addr  output  16  byte address
- mem_wdata  output  8  byte store data
- mem_rdata  input  8  byte load data, valid when mem_ack=1
- mem_ack  input  1  memory accepts or completes the current byte

Behaviour:
- Reset (async, any time): state=IDLE; busy, done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata = 0; timeout counter = 0. mem_req drops immediately, even mid-transaction. Partial loads are discarded.
- All outputs are registered or state-decoded (Moore). No combinational path exists from mem_ack to mem_req.
- FSM states: IDLE, LO, GAP, HI, DONE.
- IDLE:
  - start=1 at an edge latches addr_q, wdata_q and write_q, clears err, and moves to LO.
  - start while not in IDLE (including DONE) is ignored; no queueing.
- LO:
  - Drives mem_req=1, mem_we=write_q, mem_addr=addr_q, mem_wdata=wdata_q[7:0]. These are stable until ack.
  - mem_ack=1 at an edge: on a load, capture mem_rdata into lo_stage. Then go to GAP.
- GAP: mem_req=0 for exactly one cycle, then go to HI. This guarantees the request strobe deasserts between bytes.
- HI:
  - Drives mem_req=1, mem_addr=addr_q+1 modulo 2^16 (0xFFFF wraps to 0x0000), mem_wdata=wdata_q[15:8].
  - mem_ack=1 at an edge: on a load, rdata <= {mem_rdata, lo_stage}. Then go to DONE.
- DONE: done=1 for one cycle, mem_req=0, then go to IDLE.
- Timeout:
  - The counter clears on entry to LO and to HI, and increments each cycle in LO or HI without mem_ack.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero): err<=1, go to DONE, rdata unchanged.
  - Memory writes already acked (low byte) are not rolled back.
- mem_ack outside LO/HI is ignored.
- err holds its value until the next accepted start.
- Latency: start sampled at edge k, zero-wait ack. LO after k; GAP after k+1; HI after k+2; DONE after k+3; done high during cycle k+3; IDLE after k+4. Minimum 4 cycles from start to done.
- Each cycle mem_ack is withheld adds one cycle per byte.
- rdata changes only at HI completion of a successful load. It is unchanged by stores and timeouts.

Test Plan:
- Load, zero-wait: memory[0x0040]=0x34, [0x0041]=0x12; start, write=0, addr=0x0040 -> mem_addr 0x0040 then 0x0041, mem_req low one cycle between bytes; done 4 cycles after start; rdata=0x1234, err=0.
- Store with 2 wait states per byte: addr=0x0100, wdata=0xBEEF -> byte 0xEF with mem_we=1 at 0x0100, then 0xBE at 0x0101; req/addr/data stable while waiting; done after 8 cycles; rdata unchanged.
- Wrap: load at addr=0xFFFF with [0xFFFF]=0xAA, [0x0000]=0x55 -> second mem_addr=0x0000; rdata=0x55AA.
- Timeout: TIMEOUT_CYCLES=16, never ack the high byte -> done with err=1 after 16 HI cycles; rdata keeps its previous value; next start clears err.
- Reset mid-HI: assert reset between edges -> mem_req and busy drop immediately, before the next edge; rdata=0; next start runs a normal transfer.
- start held high for 6 cycles from IDLE -> exactly one transfer; a start pulsed during DONE is ignored, busy=0 afterwards.
